// File: rtl/aes_decipher_block.sv
// aes_decipher_block: iterative AES inverse cipher, one S-box word per cycle.
// Optional feature macro AES_DECIPHER_NEXT_ERR_EN adds the next_err output.
module aes_decipher_block (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
`ifdef AES_DECIPHER_NEXT_ERR_EN
    ,
    output logic         next_err
`endif
);

    localparam logic       AES_128_BIT_KEY = 1'h0;
    localparam logic       AES_256_BIT_KEY = 1'h1;
    localparam logic [3:0] AES128_ROUNDS   = 4'ha;
    localparam logic [3:0] AES256_ROUNDS   = 4'he;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        SBOX = 2'd2,
        MAIN = 2'd3
    } state_t;

    state_t      state_reg, state_new;
    logic [3:0]  round_ctr_reg, round_ctr_new;
    logic [1:0]  sword_ctr_reg, sword_ctr_new;
    logic        keylen_reg, keylen_new;
    logic        ready_reg, ready_new;
    logic [31:0] w_reg [4];
    logic [31:0] w_new [4];

    logic [127:0] cur_blk;
    logic [127:0] addk_blk;
    logic [127:0] init_blk;
    logic [127:0] main_blk;

    function automatic logic [3:0] num_rounds(input logic kl);
        logic [3:0] n;
        case (kl)
            AES_128_BIT_KEY: n = AES128_ROUNDS;
            AES_256_BIT_KEY: n = AES256_ROUNDS;
            default:         n = AES128_ROUNDS;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m09(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] m0b(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] m0d(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] m0e(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    function automatic logic [31:0] imc_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {m0e(a0) ^ m0b(a1) ^ m0d(a2) ^ m09(a3),
                m09(a0) ^ m0e(a1) ^ m0b(a2) ^ m0d(a3),
                m0d(a0) ^ m09(a1) ^ m0e(a2) ^ m0b(a3),
                m0b(a0) ^ m0d(a1) ^ m09(a2) ^ m0e(a3)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] b);
        return {imc_col(b[127:96]), imc_col(b[95:64]),
                imc_col(b[63:32]), imc_col(b[31:0])};
    endfunction

    // Row r of the state rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] b);
        logic [31:0] w0, w1, w2, w3;
        w0 = b[127:96];
        w1 = b[95:64];
        w2 = b[63:32];
        w3 = b[31:0];
        return {w0[31:24], w3[23:16], w2[15:8], w1[7:0],
                w1[31:24], w0[23:16], w3[15:8], w2[7:0],
                w2[31:24], w1[23:16], w0[15:8], w3[7:0],
                w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
    endfunction

    assign cur_blk   = {w_reg[0], w_reg[1], w_reg[2], w_reg[3]};
    assign addk_blk  = cur_blk ^ round_key;
    assign init_blk  = inv_shift_rows(block ^ round_key);
    assign main_blk  = inv_shift_rows(inv_mix_columns(addk_blk));

    assign round     = round_ctr_reg;
    assign new_block = cur_blk;
    assign ready     = ready_reg;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            round_ctr_reg <= 4'd0;
            sword_ctr_reg <= 2'd0;
            keylen_reg    <= 1'b0;
            ready_reg     <= 1'b1;
            for (int i = 0; i < 4; i++) w_reg[i] <= 32'h0;
        end else begin
            state_reg     <= state_new;
            round_ctr_reg <= round_ctr_new;
            sword_ctr_reg <= sword_ctr_new;
            keylen_reg    <= keylen_new;
            ready_reg     <= ready_new;
            for (int i = 0; i < 4; i++) w_reg[i] <= w_new[i];
        end
    end

    // Next-state, round sequencing and S-box word selection.
    always_comb begin
        state_new     = state_reg;
        round_ctr_new = round_ctr_reg;
        sword_ctr_new = sword_ctr_reg;
        keylen_new    = keylen_reg;
        ready_new     = ready_reg;
        sboxw         = 32'h0;
        for (int i = 0; i < 4; i++) w_new[i] = w_reg[i];

        case (state_reg)
            IDLE: begin
                if (next) begin
                    ready_new     = 1'b0;
                    round_ctr_new = num_rounds(keylen);
                    keylen_new    = keylen;
                    state_new     = INIT;
                end
            end
            INIT: begin
                {w_new[0], w_new[1], w_new[2], w_new[3]} = init_blk;
                round_ctr_new = round_ctr_reg - 4'd1;
                sword_ctr_new = 2'd0;
                state_new     = SBOX;
            end
            SBOX: begin
                sboxw                = w_reg[sword_ctr_reg];
                w_new[sword_ctr_reg] = new_sboxw;
                sword_ctr_new        = sword_ctr_reg + 2'd1;
                if (sword_ctr_reg == 2'd3) state_new = MAIN;
            end
            MAIN: begin
                if (round_ctr_reg != 4'd0) begin
                    {w_new[0], w_new[1], w_new[2], w_new[3]} = main_blk;
                    round_ctr_new = round_ctr_reg - 4'd1;
                    sword_ctr_new = 2'd0;
                    state_new     = SBOX;
                end else begin
                    {w_new[0], w_new[1], w_new[2], w_new[3]} = addk_blk;
                    ready_new = 1'b1;
                    state_new = IDLE;
                end
            end
            default: begin
                state_new = IDLE;
                ready_new = 1'b1;
            end
        endcase
    end

`ifdef AES_DECIPHER_NEXT_ERR_EN
    // Flags a start request that arrived while an operation was running.
    always_ff @(posedge clk) begin
        if (reset) next_err <= 1'b0;
        else       next_err <= next && (state_reg != IDLE);
    end
`endif

endmodule

// File: tb/tb_aes_decipher_block.sv
// tb_aes_decipher_block: FIPS-197 vectors through aes_decipher_block.
// Key memory and inverse S-box are modelled here; a scoreboard checks results.
module tb_aes_decipher_block;

    logic         clk = 1'b0;
    logic         reset;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;
`ifdef AES_DECIPHER_NEXT_ERR_EN
    logic         next_err;
`endif

    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PTB  = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [127:0] pt;
        int           done;
        string        nm;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic         rst_q = 1'b1;
    logic [7:0]   sbox_t  [256];
    logic [7:0]   isbox_t [256];
    logic [127:0] rk_tab  [16];

    aes_decipher_block dut (
        .clk       (clk),
        .reset     (reset),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
`ifdef AES_DECIPHER_NEXT_ERR_EN
        ,
        .next_err  (next_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    assign round_key = rk_tab[round];
    assign new_sboxw = {isbox_t[sboxw[31:24]], isbox_t[sboxw[23:16]],
                        isbox_t[sboxw[15:8]],  isbox_t[sboxw[7:0]]};

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] b;
        logic [7:0] s;
        for (int i = 0; i < 256; i++) begin
            b = 8'h01;
            for (int k = 0; k < 254; k++) b = gmul(b, 8'(i));
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                  ^ {b[3:0], b[7:4]} ^ 8'h63;
            sbox_t[i]  = s;
            isbox_t[s] = 8'(i);
        end
    endtask

    task automatic expand(input logic [255:0] key, input bit k256);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nk;
        int          nr;
        nk = k256 ? 8 : 4;
        nr = k256 ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 16; r++) rk_tab[r] = 128'h0;
        for (int r = 0; r <= nr; r++)
            rk_tab[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        logic pr;
        exp_t e;
        pr = 1'b1;
        forever begin
            @(negedge clk);
            if (ready === 1'b1 && pr === 1'b0 && rst_q !== 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ready: got %h want none", new_block);
                end else begin
                    e = sb.pop_front();
                    chk({e.nm, "_data"}, new_block, e.pt);
                    chk({e.nm, "_latency"}, 128'(cyc), 128'(e.done));
                end
            end
            pr = ready;
        end
    endtask

    task automatic issue(input logic kl, input logic [127:0] ct,
                         input logic [127:0] pt, input bit push, input string nm);
        keylen = kl;
        block  = ct;
        next   = 1'b1;
        if (push) sb.push_back('{pt: pt, done: cyc + 2 + (kl ? 70 : 50), nm: nm});
        @(negedge clk);
        next = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while ((sb.size() != 0 || ready !== 1'b1) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0 || ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d pending want 0 after %0d cycles",
                     sb.size(), budget);
            sb.delete();
        end
    endtask

    initial begin
        int base;
        int j;
        reset  = 1'b1;
        next   = 1'b0;
        keylen = 1'b0;
        block  = 128'h0;
        build_sbox();
        expand(K128, 1'b0);
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_ready", 128'(ready), 128'(1));
        chk("reset_block", new_block, 128'h0);
        chk("reset_round", 128'(round), 128'(0));
        chk("reset_sboxw", 128'(sboxw), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        // AES-128 with round / sboxw / ready trace.
        issue(1'b0, CT1, PT, 1'b1, "aes128");
        for (j = 0; j <= 50; j++) begin
            chk($sformatf("trace_%0d", j),
                {91'h0, round, ready, (j != 0 && j % 5 != 0) ? 32'h0 : sboxw},
                {91'h0, (j == 0) ? 4'd10 : 4'(9 - (j - 1) / 5), 1'b0, 32'h0});
            @(negedge clk);
        end
        wait_done(20);

        // AES-256.
        expand(K256, 1'b1);
        issue(1'b1, CT2, PT, 1'b1, "aes256");
        wait_done(90);

        // Reset in the middle of an AES-128 operation, then rerun.
        expand(K128, 1'b0);
        base = cyc;
        issue(1'b0, CT1, PT, 1'b0, "abort");
        while (cyc < base + 20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready", 128'(ready), 128'(1));
        chk("abort_block", new_block, 128'h0);
        chk("abort_round", 128'(round), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        issue(1'b0, CT1, PT, 1'b1, "rerun");
        wait_done(80);

        // Stray next, keylen and block changes while busy.
        base = cyc;
        issue(1'b0, CT1, PT, 1'b1, "busy_next");
        while (cyc < base + 52) begin
            case (cyc - base)
                10: begin
`ifdef AES_DECIPHER_NEXT_ERR_EN
                    chk("next_err_c10", 128'(next_err), 128'(0));
`endif
                    next = 1'b1;
                end
                11: begin
`ifdef AES_DECIPHER_NEXT_ERR_EN
                    chk("next_err_c11", 128'(next_err), 128'(1));
`endif
                    next = 1'b0;
                end
                12: begin
`ifdef AES_DECIPHER_NEXT_ERR_EN
                    chk("next_err_c12", 128'(next_err), 128'(0));
`endif
                    keylen = 1'b1;
                    block  = 128'hdeadbeef_01234567_89abcdef_cafef00d;
                end
                default: ;
            endcase
            @(negedge clk);
        end
        wait_done(20);
        keylen = 1'b0;

        // next held high: two back-to-back operations, new key and block
        // supplied in the idle cycle between them.
        base   = cyc;
        keylen = 1'b0;
        block  = CT1;
        next   = 1'b1;
        sb.push_back('{pt: PT, done: base + 52, nm: "b2b_first"});
        while (cyc < base + 52) @(negedge clk);
        expand(KB, 1'b0);
        block = CTB;
        sb.push_back('{pt: PTB, done: base + 104, nm: "b2b_second"});
        @(negedge clk);
        next = 1'b0;
        wait_done(80);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
